// File: rtl/apb_bus_wd.sv
// APB single-master to N-slave demux with registered setup-phase decode,
// a per-access watchdog that answers hung slaves with PSLVERR, and sticky
// per-slave timeout flags.
// Ports: clk_i/rst_ni; master side p*_i in, pready_o/prdata_o/pslverr_o out;
// slave side flat N_SLV-wide p*_o out, pready_i/prdata_i/pslverr_i in;
// tmo_sticky_o flags with tmo_clr_i clear mask.
module apb_bus_wd #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int N_SLV          = 2,
  parameter logic [N_SLV-1:0][ADDR_WIDTH-1:0] ADDR_BEGIN = '0,
  parameter logic [N_SLV-1:0][ADDR_WIDTH-1:0] ADDR_END   = '0,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [ADDR_WIDTH-1:0]         paddr_i,
  input  logic [2:0]                    pprot_i,
  input  logic                          psel_i,
  input  logic                          penable_i,
  input  logic                          pwrite_i,
  input  logic [DATA_WIDTH-1:0]         pwdata_i,
  input  logic [STRB_WIDTH-1:0]         pstrb_i,
  output logic                          pready_o,
  output logic [DATA_WIDTH-1:0]         prdata_o,
  output logic                          pslverr_o,
  output logic [N_SLV*ADDR_WIDTH-1:0]   paddr_o,
  output logic [N_SLV*3-1:0]            pprot_o,
  output logic [N_SLV-1:0]              pwrite_o,
  output logic [N_SLV*DATA_WIDTH-1:0]   pwdata_o,
  output logic [N_SLV*STRB_WIDTH-1:0]   pstrb_o,
  output logic [N_SLV-1:0]              psel_o,
  output logic [N_SLV-1:0]              penable_o,
  input  logic [N_SLV-1:0]              pready_i,
  input  logic [N_SLV*DATA_WIDTH-1:0]   prdata_i,
  input  logic [N_SLV-1:0]              pslverr_i,
  output logic [N_SLV-1:0]              tmo_sticky_o,
  input  logic [N_SLV-1:0]              tmo_clr_i
);

  localparam int SEL_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam int CNT_W =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  function automatic bit cfg_ok();
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < N_SLV; i++) begin
      if (ADDR_BEGIN[i] > ADDR_END[i]) ok = 1'b0;
      for (int j = i + 1; j < N_SLV; j++) begin
        if (!(ADDR_END[i] < ADDR_BEGIN[j] ||
              ADDR_END[j] < ADDR_BEGIN[i])) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  localparam bit CFG_OK = cfg_ok();

  if (!CFG_OK) begin : g_cfg_err
    $fatal(1, "apb_bus_wd: address windows overlap or are inverted");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DERR,
    TMO
  } state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             hit_q, hit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_SLV-1:0] sticky_q;
  logic [N_SLV-1:0] tmo_set;

  logic [ADDR_WIDTH-1:0] off [N_SLV];
  logic                  dec_hit;
  logic [SEL_W-1:0]      dec_idx;

  logic                  slv_rdy;
  logic                  slv_err;
  logic [DATA_WIDTH-1:0] slv_rd;

  logic                  rdy_v;
  logic                  err_v;
  logic [DATA_WIDTH-1:0] rd_v;
  logic [N_SLV-1:0]      sel_v;
  logic [N_SLV-1:0]      en_v;

  // Offset arithmetic doubles as the window test: with begin <= end,
  // addr lies in [begin, end] iff (addr - begin) mod 2^W <= end - begin.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = 0; i < N_SLV; i++) begin
      off[i] = paddr_i - ADDR_BEGIN[i];
      if (off[i] <= ADDR_END[i] - ADDR_BEGIN[i]) begin
        dec_hit = 1'b1;
        dec_idx = SEL_W'(i);
      end
    end
  end

  always_comb begin
    slv_rdy = 1'b0;
    slv_err = 1'b0;
    slv_rd  = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (sel_q == SEL_W'(i)) begin
        slv_rdy = pready_i[i];
        slv_err = pslverr_i[i];
        slv_rd  = prdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    hit_d   = hit_q;
    cnt_d   = cnt_q;
    tmo_set = '0;
    rdy_v   = 1'b0;
    err_v   = 1'b0;
    rd_v    = '0;
    sel_v   = '0;
    en_v    = '0;
    unique case (state_q)
      IDLE: begin
        if (psel_i && !penable_i) begin
          if (dec_hit) begin
            sel_d   = dec_idx;
            hit_d   = 1'b1;
            state_d = ACCESS;
          end else begin
            hit_d   = 1'b0;
            state_d = DERR;
          end
        end
      end
      ACCESS: begin
        sel_v[sel_q] = psel_i & hit_q;
        en_v[sel_q]  = psel_i & hit_q & penable_i;
        // Response is withheld once the master drops psel (abort).
        rdy_v = psel_i & slv_rdy;
        err_v = psel_i & slv_err;
        rd_v  = slv_rd;
        if (!psel_i) begin
          state_d = IDLE;
        end else if (penable_i && slv_rdy) begin
          state_d = IDLE;
        end else if (WD_EN && penable_i && cnt_q == CNT_LAST) begin
          state_d = TMO;
        end else if (penable_i && cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DERR: begin
        if (!psel_i) begin
          state_d = IDLE;
        end else if (penable_i) begin
          rdy_v   = 1'b1;
          err_v   = 1'b1;
          state_d = IDLE;
        end
      end
      TMO: begin
        rdy_v          = 1'b1;
        err_v          = 1'b1;
        tmo_set[sel_q] = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      hit_q    <= 1'b0;
      cnt_q    <= '0;
      sticky_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      hit_q    <= hit_d;
      cnt_q    <= cnt_d;
      // A timeout landing together with its clear keeps the flag set.
      sticky_q <= (sticky_q & ~tmo_clr_i) | tmo_set;
    end
  end

  for (genvar g = 0; g < N_SLV; g++) begin : g_addr
    assign paddr_o[g*ADDR_WIDTH +: ADDR_WIDTH] = rst_ni ? off[g] : '0;
  end

  assign pprot_o      = rst_ni ? {N_SLV{pprot_i}}  : '0;
  assign pwrite_o     = rst_ni ? {N_SLV{pwrite_i}} : '0;
  assign pwdata_o     = rst_ni ? {N_SLV{pwdata_i}} : '0;
  assign pstrb_o      = rst_ni ? {N_SLV{pstrb_i}}  : '0;
  assign psel_o       = rst_ni ? sel_v : '0;
  assign penable_o    = rst_ni ? en_v  : '0;
  assign pready_o     = rst_ni & rdy_v;
  assign pslverr_o    = rst_ni & err_v;
  assign prdata_o     = rst_ni ? rd_v : '0;
  assign tmo_sticky_o = sticky_q;

endmodule

// File: tb/tb_apb_bus_wd.sv
// Self-checking bench for apb_bus_wd: randomized APB transfers compared
// against a window/latency model, plus reset, abort, sticky and no-watchdog.
module tb_apb_bus_wd;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NS  = 2;
  localparam int TMO = 4;
  localparam logic [NS-1:0][AW-1:0] AB = {32'h100, 32'h000};
  localparam logic [NS-1:0][AW-1:0] AE = {32'h1FF, 32'h0FF};

  logic clk = 1'b0;
  logic rst_n;

  logic [AW-1:0]    paddr;
  logic [2:0]       pprot;
  logic             psel, penable, pwrite;
  logic [DW-1:0]    pwdata;
  logic [3:0]       pstrb;
  logic             pready_m, pslverr_m;
  logic [DW-1:0]    prdata_m;
  logic [NS*AW-1:0] paddr_s;
  logic [NS*3-1:0]  pprot_s;
  logic [NS-1:0]    pwrite_s, psel_s, penable_s;
  logic [NS*DW-1:0] pwdata_s;
  logic [NS*4-1:0]  pstrb_s;
  logic [NS-1:0]    pready_s, pslverr_s;
  logic [NS*DW-1:0] prdata_s;
  logic [NS-1:0]    sticky, tmo_clr;

  logic [AW-1:0]    z_paddr;
  logic             z_psel, z_penable;
  logic             z_pready, z_pslverr;
  logic [DW-1:0]    z_prdata;
  logic [NS*AW-1:0] z_paddr_s;
  logic [NS*3-1:0]  z_pprot_s;
  logic [NS-1:0]    z_pwrite_s, z_psel_s, z_penable_s, z_sticky;
  logic [NS*DW-1:0] z_pwdata_s;
  logic [NS*4-1:0]  z_pstrb_s;

  int checks = 0;
  int errors = 0;
  logic [NS-1:0] sticky_exp = '0;

  always #5 clk = ~clk;

  apb_bus_wd #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_SLV(NS),
    .ADDR_BEGIN(AB), .ADDR_END(AE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .paddr_i(paddr), .pprot_i(pprot), .psel_i(psel),
    .penable_i(penable), .pwrite_i(pwrite),
    .pwdata_i(pwdata), .pstrb_i(pstrb),
    .pready_o(pready_m), .prdata_o(prdata_m),
    .pslverr_o(pslverr_m),
    .paddr_o(paddr_s), .pprot_o(pprot_s), .pwrite_o(pwrite_s),
    .pwdata_o(pwdata_s), .pstrb_o(pstrb_s),
    .psel_o(psel_s), .penable_o(penable_s),
    .pready_i(pready_s), .prdata_i(prdata_s),
    .pslverr_i(pslverr_s),
    .tmo_sticky_o(sticky), .tmo_clr_i(tmo_clr)
  );

  apb_bus_wd #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_SLV(NS),
    .ADDR_BEGIN(AB), .ADDR_END(AE), .TIMEOUT_CYCLES(0)
  ) dut_nowd (
    .clk_i(clk), .rst_ni(rst_n),
    .paddr_i(z_paddr), .pprot_i(pprot), .psel_i(z_psel),
    .penable_i(z_penable), .pwrite_i(pwrite),
    .pwdata_i(pwdata), .pstrb_i(pstrb),
    .pready_o(z_pready), .prdata_o(z_prdata),
    .pslverr_o(z_pslverr),
    .paddr_o(z_paddr_s), .pprot_o(z_pprot_s), .pwrite_o(z_pwrite_s),
    .pwdata_o(z_pwdata_s), .pstrb_o(z_pstrb_s),
    .psel_o(z_psel_s), .penable_o(z_penable_s),
    .pready_i(pready_s), .prdata_i(prdata_s),
    .pslverr_i(pslverr_s),
    .tmo_sticky_o(z_sticky), .tmo_clr_i(tmo_clr)
  );

  // One APB transfer; expectations come from the address map and the
  // slave wait count: a miss answers in access cycle 1, a slave that
  // stays silent TMO cycles is answered with an error in cycle TMO+1.
  task automatic do_xfer(input logic [AW-1:0] addr, input logic wr,
                         input int wait_n, input bit mid,
                         input logic [AW-1:0] mid_addr,
                         input bit clr_resp);
    bit            hit, tmo, serr;
    int            k, n_resp;
    logic [AW-1:0] cur, oexp;
    logic [DW-1:0] wd, rexp;
    logic [NS-1:0] ex_sel;
    logic          eexp;
    hit    = (addr < 32'h200);
    k      = hit ? int'(addr >> 8) : 0;
    tmo    = hit && (wait_n >= TMO);
    n_resp = !hit ? 1 : (tmo ? TMO + 1 : wait_n + 1);
    serr   = 1'($urandom);
    cur    = addr;
    wd     = $urandom;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr;
    pwdata = wd; pstrb = 4'($urandom); pprot = 3'($urandom);
    pready_s = '0; pslverr_s = '0; tmo_clr = '0;
    @(negedge clk);
    checks++;
    if (psel_s !== '0 || pready_m !== 1'b0) begin
      errors++;
      $display("FAIL setup: psel_o=%b pready_o=%b required 00/0",
               psel_s, pready_m);
    end
    checks++;
    if (pwdata_s !== {NS{wd}} || pwrite_s !== {NS{wr}} ||
        pstrb_s !== {NS{pstrb}} || pprot_s !== {NS{pprot}}) begin
      errors++;
      $display("FAIL bcast: wdata=%h wr=%b strb=%h prot=%h for %h/%b",
               pwdata_s, pwrite_s, pstrb_s, pprot_s, wd, wr);
    end
    for (int n = 1; n <= n_resp; n++) begin
      @(posedge clk); #1;
      penable = 1'b1;
      if (mid && n == 2) begin
        cur = mid_addr;
        paddr = mid_addr;
      end
      prdata_s = {$urandom, $urandom};
      pready_s = '0;
      pslverr_s = '0;
      pready_s[1-k] = 1'($urandom);
      pslverr_s[1-k] = 1'($urandom);
      if (hit && !tmo && n == n_resp) begin
        pready_s[k] = 1'b1;
        pslverr_s[k] = serr;
      end
      tmo_clr = (clr_resp && n == n_resp) ? NS'(1 << k) : '0;
      @(negedge clk);
      ex_sel = (hit && !(tmo && n == n_resp)) ? NS'(1 << k) : '0;
      checks++;
      if (psel_s !== ex_sel || penable_s !== ex_sel) begin
        errors++;
        $display("FAIL sel @%h cyc %0d: psel=%b pen=%b required %b",
                 addr, n, psel_s, penable_s, ex_sel);
      end
      checks++;
      if (pready_m !== (n == n_resp)) begin
        errors++;
        $display("FAIL ready @%h cyc %0d: got %b required %b",
                 addr, n, pready_m, (n == n_resp));
      end
      if (n == n_resp) begin
        eexp = (!hit || tmo) ? 1'b1 : serr;
        rexp = (!hit || tmo) ? '0 : prdata_s[k*DW +: DW];
        checks++;
        if (pslverr_m !== eexp || prdata_m !== rexp) begin
          errors++;
          $display("FAIL resp @%h: err=%b rdata=%h required %b/%h",
                   addr, pslverr_m, prdata_m, eexp, rexp);
        end
      end
      for (int i = 0; i < NS; i++) begin
        oexp = cur - AW'(i * 256);
        checks++;
        if (paddr_s[i*AW +: AW] !== oexp) begin
          errors++;
          $display("FAIL paddr[%0d]: got %h required %h",
                   i, paddr_s[i*AW +: AW], oexp);
        end
      end
    end
    if (tmo) sticky_exp[k] = 1'b1;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    pready_s = '0; pslverr_s = '0; tmo_clr = '0;
    @(negedge clk);
    checks++;
    if (psel_s !== '0 || pready_m !== 1'b0 || sticky !== sticky_exp) begin
      errors++;
      $display("FAIL idle: psel=%b rdy=%b sticky=%b required 00/0/%b",
               psel_s, pready_m, sticky, sticky_exp);
    end
  endtask

  task automatic check_all_zero(input string nm);
    checks++;
    if (psel_s !== '0 || penable_s !== '0 || pready_m !== 1'b0 ||
        pslverr_m !== 1'b0 || prdata_m !== '0 || paddr_s !== '0 ||
        pwdata_s !== '0 || pwrite_s !== '0 || pstrb_s !== '0 ||
        pprot_s !== '0 || sticky !== '0) begin
      errors++;
      $display("FAIL %s: sel=%b en=%b rdy=%b err=%b rd=%h a=%h st=%b",
               nm, psel_s, penable_s, pready_m, pslverr_m, prdata_m,
               paddr_s, sticky);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    paddr = 32'h123; pprot = 3'h5; psel = 1'b1; penable = 1'b0;
    pwrite = 1'b1; pwdata = 32'hDEAD_BEEF; pstrb = 4'hF;
    pready_s = '1; pslverr_s = '1; prdata_s = '1; tmo_clr = '0;
    z_paddr = '0; z_psel = 1'b0; z_penable = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    psel = 1'b0; pready_s = '0; pslverr_s = '0;
    #2 rst_n = 1'b1;
    idle();
  endtask

  task automatic test_decode();
    do_xfer(32'h0000_00FF, 1'b0, 0, 1'b0, '0, 1'b0);
    do_xfer(32'h0000_0100, 1'b1, 0, 1'b0, '0, 1'b0);
    do_xfer(32'h0000_0000, 1'b0, 1, 1'b0, '0, 1'b0);
    do_xfer(32'h0000_01FF, 1'b0, 0, 1'b0, '0, 1'b0);
    do_xfer(32'h0000_0104, 1'b0, 2, 1'b0, '0, 1'b0);
    do_xfer(32'h0000_0200, 1'b1, 0, 1'b0, '0, 1'b0);
    do_xfer(32'h0000_0300, 1'b1, 0, 1'b0, '0, 1'b0);
    do_xfer(32'hFFFF_FFFF, 1'b0, 0, 1'b0, '0, 1'b0);
    idle();
  endtask

  task automatic test_timeout();
    do_xfer(32'h0000_0010, 1'b0, TMO - 1, 1'b0, '0, 1'b0);
    idle();
    do_xfer(32'h0000_0020, 1'b1, 50, 1'b0, '0, 1'b0);
    idle();
  endtask

  task automatic test_sticky();
    @(posedge clk); #1 tmo_clr = 2'b01;
    sticky_exp[0] = 1'b0;
    @(posedge clk); #1 tmo_clr = '0;
    @(negedge clk);
    checks++;
    if (sticky !== sticky_exp) begin
      errors++;
      $display("FAIL clr: sticky=%b required %b", sticky, sticky_exp);
    end
    do_xfer(32'h0000_0030, 1'b0, 9, 1'b0, '0, 1'b1);
    idle();
    do_xfer(32'h0000_0180, 1'b0, 7, 1'b0, '0, 1'b0);
    idle();
    @(posedge clk); #1 tmo_clr = 2'b10;
    sticky_exp[1] = 1'b0;
    idle();
  endtask

  task automatic test_addr_change();
    do_xfer(32'h0000_0040, 1'b0, 2, 1'b1, 32'h0000_0150, 1'b0);
    do_xfer(32'h0000_0140, 1'b1, 3, 1'b1, 32'h0000_0010, 1'b0);
    idle();
  endtask

  task automatic test_abort();
    do_xfer(32'h0000_0120, 1'b0, 0, 1'b0, '0, 1'b0);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 32'h0000_0120;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    #1;
    checks++;
    if (psel_s !== '0 || penable_s !== '0 || pready_m !== 1'b0) begin
      errors++;
      $display("FAIL abort: psel=%b pen=%b rdy=%b required 00/00/0",
               psel_s, penable_s, pready_m);
    end
    do_xfer(32'h0000_0050, 1'b1, 1, 1'b0, '0, 1'b0);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 32'h0000_0400;
    @(posedge clk); #1;
    psel = 1'b0;
    #1;
    checks++;
    if (pready_m !== 1'b0 || pslverr_m !== 1'b0) begin
      errors++;
      $display("FAIL derr_abort: rdy=%b err=%b required 0/0",
               pready_m, pslverr_m);
    end
    do_xfer(32'h0000_0108, 1'b0, 1, 1'b0, '0, 1'b0);
    idle();
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    int r;
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 2);
      if (r == 0) a = AW'($urandom_range(0, 32'hFF));
      else if (r == 1) a = AW'($urandom_range(32'h100, 32'h1FF));
      else a = AW'($urandom_range(32'h200, 32'hFFFF_FFFF));
      do_xfer(a, 1'($urandom), $urandom_range(0, 5), 1'b0, '0, 1'b0);
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 32'h0000_0104;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk); #2;
    rst_n = 1'b0;
    sticky_exp = '0;
    #1;
    check_all_zero("reset_mid");
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    do_xfer(32'h0000_0104, 1'b0, 2, 1'b0, '0, 1'b0);
    idle();
  endtask

  task automatic test_no_watchdog();
    logic [DW-1:0] rexp;
    int bad = 0;
    @(posedge clk); #1;
    z_psel = 1'b1; z_penable = 1'b0; z_paddr = 32'h0000_0180;
    pready_s = '0; pslverr_s = '0;
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk); #1 z_penable = 1'b1;
      @(negedge clk);
      if (z_pready !== 1'b0 || z_psel_s !== 2'b10) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL nowd_stall: %0d bad cycles required 0", bad);
    end
    @(posedge clk); #1;
    prdata_s = {$urandom, $urandom};
    pready_s = 2'b10;
    @(negedge clk);
    rexp = prdata_s[DW +: DW];
    checks++;
    if (z_pready !== 1'b1 || z_pslverr !== 1'b0 ||
        z_prdata !== rexp || z_sticky !== '0) begin
      errors++;
      $display("FAIL nowd_resp: rdy=%b err=%b rd=%h st=%b req 1/0/%h/00",
               z_pready, z_pslverr, z_prdata, z_sticky, rexp);
    end
    @(posedge clk); #1;
    z_psel = 1'b0; z_penable = 1'b0; pready_s = '0;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_timeout();
    test_sticky();
    test_addr_change();
    test_abort();
    test_random();
    test_reset_mid();
    test_no_watchdog();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
